// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// One operation in flight; special cases (divide by zero, signed overflow) bypass the iteration.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_q, state_d;
  logic            alive_q;
  logic [5:0]      cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] out_q, out_d;
  logic [XLEN:0]   rem_q, rem_d;

  logic            signed_in;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN-1:0] special_res;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   rem_nx;
  logic            take;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  assign in_ready  = alive_q && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;

  // Operand conditioning at accept time: magnitudes only for the signed ops.
  assign signed_in   = ~div_op[0];
  assign a_abs       = (signed_in && a_i[XLEN-1]) ? -a_i : a_i;
  assign b_abs       = (signed_in && b_i[XLEN-1]) ? -b_i : b_i;
  assign div_zero    = (b_i == '0);
  assign ovf         = signed_in && (a_i == MIN_INT) && (b_i == {XLEN{1'b1}});
  assign special_res = div_zero ? (div_op[1] ? a_i : {XLEN{1'b1}})
                                : (div_op[1] ? '0 : MIN_INT);

  // One restoring step; rem_q[XLEN] only guards the compare and is never set in practice.
  assign rem_sh  = {rem_q[XLEN-1:0], dvd_q[XLEN-1]};
  assign take    = rem_q[XLEN] | (rem_sh >= {1'b0, dsr_q});
  assign rem_nx  = take ? (rem_sh - {1'b0, dsr_q}) : rem_sh;
  assign quo_nx  = {quo_q[XLEN-2:0], take};
  assign quo_fix = (~op_q[0] && qneg_q) ? -quo_nx : quo_nx;
  assign rem_fix = (~op_q[0] && rneg_q) ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          op_d   = div_op;
          qneg_d = a_i[XLEN-1] ^ b_i[XLEN-1];
          rneg_d = a_i[XLEN-1];
          if (div_zero || ovf) begin
            out_d   = special_res;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
            cnt_d   = 6'd31;
            dvd_d   = a_abs;
            dsr_d   = b_abs;
            quo_d   = '0;
            rem_d   = '0;
          end
        end
      end
      S_CALC: begin
        dvd_d = dvd_q << 1;
        rem_d = rem_nx;
        quo_d = quo_nx;
        if (cnt_q == 6'd0) begin
          out_d   = op_q[1] ? rem_fix : quo_fix;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      alive_q <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
// Transaction-level model plus directed vectors with literal expectations.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  div_op = 2'b00;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;

  int n_tests = 0;
  int n_fail  = 0;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .div_op(div_op), .a_i(a_i), .b_i(b_i), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RISC-V M-extension semantics in plain arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
  endfunction

  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  logic        m_alive, m_busy, m_valid;
  int          m_cnt;
  logic [31:0] m_res;
  logic        m_ready;
  assign m_ready = m_alive && !m_busy && !m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_alive <= 1'b0; m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0; m_res <= '0;
    end else begin
      m_alive <= 1'b1;
      if (flush) begin
        m_busy <= 1'b0; m_valid <= 1'b0;
      end else if (m_valid) begin
        if (out_ready) m_valid <= 1'b0;
      end else if (m_busy) begin
        if (m_cnt == 1) begin m_busy <= 1'b0; m_valid <= 1'b1; end
        else m_cnt <= m_cnt - 1;
      end else if (m_alive && in_valid) begin
        m_res <= ref_div(div_op, a_i, b_i);
        if (is_special(div_op, a_i, b_i)) m_valid <= 1'b1;
        else begin m_busy <= 1'b1; m_cnt <= 32; end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_in_ready", {31'b0, in_ready}, {31'b0, m_ready});
      chk("model_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      if (m_valid) chk("model_out", out, m_res);
    end
  end

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input int hold, input logic spam);
    int n;
    logic [31:0] held;
    @(negedge clk);
    chk({name, "_ready_in"}, {31'b0, in_ready}, 32'd1);
    div_op = op; a_i = a; b_i = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = spam;
    if (spam) begin a_i = 32'd9; b_i = 32'd0; end
    n = 1;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk({name, "_latency"}, n, lat);
    chk({name, "_result"}, out, exp);
    held = out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_hold_out"}, out, held);
      chk({name, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
      chk({name, "_hold_busy"}, {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_ready_after"}, {31'b0, in_ready}, 32'd1);
    chk({name, "_valid_after"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic expect_no_result(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out", out, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, in_ready}, 32'd1);

    chk("pin_divu", ref_div(2'b01, 32'd100, 32'd7), 32'd14);
    chk("pin_rem", ref_div(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("pin_div", ref_div(2'b00, 32'd7, 32'hFFFF_FFFE), 32'hFFFF_FFFD);

    run_op("divu_100_7",  2'b01, 32'd100, 32'd7, 32'd14, 33, 0, 1'b0);
    run_op("remu_100_7",  2'b11, 32'd100, 32'd7, 32'd2, 33, 0, 1'b0);
    run_op("div_m7_2",    2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, 1'b0);
    run_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, 1'b0);
    run_op("div_5_0",     2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 1'b0);
    run_op("remu_5_0",    2'b11, 32'd5, 32'd0, 32'd5, 1, 0, 1'b0);
    run_op("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 1'b0);
    run_op("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, 1'b0);
    run_op("divu_nonovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 0, 1'b0);
    run_op("divu_max_1",  2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 0, 1'b0);
    run_op("div_7_m2",    2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0, 1'b0);
    run_op("rem_7_m2",    2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0, 1'b0);
    run_op("remu_max_16", 2'b11, 32'hFFFF_FFFF, 32'd16, 32'd15, 33, 0, 1'b0);
    run_op("busy_ignore", 2'b01, 32'd100, 32'd7, 32'd14, 33, 0, 1'b1);
    run_op("hold_10",     2'b01, 32'd100, 32'd7, 32'd14, 33, 10, 1'b0);

    // flush during CALC
    @(negedge clk);
    div_op = 2'b01; a_i = 32'd100; b_i = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", {31'b0, in_ready}, 32'd1);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    expect_no_result("flush_no_result", 40);

    // flush with a request in IDLE drops it
    @(negedge clk);
    div_op = 2'b01; a_i = 32'd50; b_i = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_ready", {31'b0, in_ready}, 32'd1);
    expect_no_result("flush_idle_drop", 5);

    // flush together with out_ready in DONE
    @(negedge clk);
    div_op = 2'b00; a_i = 32'd5; b_i = 32'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("flush_done_valid", {31'b0, out_valid}, 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_done_ready", {31'b0, in_ready}, 32'd1);
    chk("flush_done_cleared", {31'b0, out_valid}, 32'd0);

    // reset pulse during CALC
    @(negedge clk);
    div_op = 2'b01; a_i = 32'd100; b_i = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out", out, 32'd0);
    chk("midrst_ready", {31'b0, in_ready}, 32'd0);
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", {31'b0, in_ready}, 32'd1);
    chk("midrst_out_after", out, 32'd0);
    expect_no_result("midrst_no_result", 40);

    run_op("after_rst", 2'b11, 32'd100, 32'd7, 32'd2, 33, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
